// File: rtl/byte_packer_pkg.sv
// Shared types, widths and the byte-keep helper for the byte packer.
package byte_packer_pkg;

  localparam int WORD_WIDTH     = 32;
  localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int CNT_WIDTH      = 3;

  localparam logic [CNT_WIDTH-1:0] BPW_CNT = CNT_WIDTH'(BYTES_PER_WORD);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pack_state_t;

  // Top `cnt` bits set; saturates to all ones once a full word is held.
  function automatic logic [BYTES_PER_WORD-1:0] keep_mask(input logic [CNT_WIDTH-1:0] cnt);
    logic [BYTES_PER_WORD-1:0] mask;
    mask = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (CNT_WIDTH'(i) < cnt) begin
        mask[BYTES_PER_WORD-1-i] = 1'b1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/byte_packer_merge.sv
// Combinational shift-and-merge: drops a masked chunk into the accumulator
// directly behind the bytes already held.
module byte_merge
  import byte_packer_pkg::*;
#(
  parameter int W = WORD_WIDTH
) (
  input  logic [W-1:0]         chunk_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic [CNT_WIDTH-1:0] offset_i,
  input  logic [2*W-1:0]       base_i,
  output logic [2*W-1:0]       merged_o,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  logic [W-1:0]   masked;
  logic [2*W-1:0] aligned;

  // Bytes past len_i are zeroed so stale encoder data never leaks into the word.
  for (genvar gi = 0; gi < W / 8; gi++) begin : g_mask
    assign masked[W-1-8*gi -: 8] = (CNT_WIDTH'(gi) < len_i) ? chunk_i[W-1-8*gi -: 8] : 8'h00;
  end

  assign aligned  = {masked, {W{1'b0}}} >> {offset_i, 3'b000};
  assign merged_o = base_i | aligned;
  assign cnt_o    = offset_i + len_i;

endmodule

// File: rtl/byte_packer.sv
// Packs 0-4 byte chunks into dense 32-bit words; drains a partial final
// word with a keep mask when the packet ends.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter int DATA_IN_WIDTH = WORD_WIDTH,
  parameter int LEN_IN_WIDTH  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_IN_WIDTH-1:0] in_data,
  input  logic [LEN_IN_WIDTH-1:0]  in_len,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_IN_WIDTH-1:0] out_data,
  output logic [3:0]               out_keep,
  output logic                     out_last
);

  localparam int ACC_W = 2 * DATA_IN_WIDTH;

  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  pack_state_t          state_q, state_d;

  logic                 out_fire, in_fire;
  logic [ACC_W-1:0]     base;
  logic [CNT_WIDTH-1:0] offset;
  logic [CNT_WIDTH-1:0] len_c;
  logic [ACC_W-1:0]     merged;
  logic [CNT_WIDTH-1:0] merged_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      state_q <= RUN;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    len_c = (in_len > LEN_IN_WIDTH'(BYTES_PER_WORD)) ? BPW_CNT : CNT_WIDTH'(in_len);
  end

  byte_merge #(.W(DATA_IN_WIDTH)) u_merge (
    .chunk_i  (in_data),
    .len_i    (len_c),
    .offset_i (offset),
    .base_i   (base),
    .merged_o (merged),
    .cnt_o    (merged_cnt)
  );

  always_comb begin
    out_valid = (cnt_q >= BPW_CNT) || (state_q == FLUSH);
    out_data  = acc_q[ACC_W-1 -: DATA_IN_WIDTH];
    out_keep  = keep_mask(cnt_q);
    out_last  = (state_q == FLUSH) && (cnt_q <= BPW_CNT);
    out_fire  = out_valid && out_ready;

    // Gated by rst_n so upstream sees not-ready for the whole reset pulse.
    in_ready  = rst_n && (state_q == RUN) && ((cnt_q < BPW_CNT) || out_fire);
    in_fire   = in_valid && in_ready;

    base   = acc_q;
    offset = cnt_q;
    if (out_fire) begin
      base = acc_q << DATA_IN_WIDTH;
      if (out_last) begin
        offset = '0;
      end else begin
        offset = cnt_q - BPW_CNT;
      end
    end

    acc_d = base;
    cnt_d = offset;
    if (in_fire) begin
      acc_d = merged;
      cnt_d = merged_cnt;
    end

    state_d = state_q;
    case (state_q)
      RUN:     if (in_fire && in_last)   state_d = FLUSH;
      FLUSH:   if (out_fire && out_last) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

endmodule

// File: doc/byte_packer.md
# byte_packer

Output packing stage of the compressor datapath. Accepts variable-length byte chunks of 0–4 bytes from the encoder with a valid/ready handshake. Concatenates them in arrival order into a 64-bit accumulator, using a shift-and-merge unit. Emits dense 32-bit words downstream, and drains a final partial word with a byte-keep mask on end-of-packet.

## Interface
Parameters:
- DATA_IN_WIDTH, 32, chunk/output word width in bits (multiple of 8)
- LEN_IN_WIDTH, 3, width of byte-length field

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  chunk present
- in_ready  out  1  chunk accepted when in_valid && in_ready
- in_data  in  DATA_IN_WIDTH  chunk bytes, MSB-aligned (byte 0 = in_data[31:24])
- in_len  in  LEN_IN_WIDTH  valid bytes in chunk, 0–4
- in_last  in  1  chunk ends the packet
- out_valid  out  1  output word present
- out_ready  in  1  downstream accepts
- out_data  out  DATA_IN_WIDTH  packed word, earliest byte in MSBs
- out_keep  out  4  byte valid mask, keep[3] = out_data[31:24]
- out_last  out  1  word ends the packet

## Operation
- State: acc[63:0], cnt (0–7 bytes valid, MSB-aligned in acc), fsm ∈ {RUN, FLUSH}.
- out_fire = out_valid && out_ready; in_fire = in_valid && in_ready.
- out_valid = (cnt ≥ 4) || (fsm == FLUSH).
- out_data = acc[63:32].
- out_keep = 4'b1111 if cnt ≥ 4, else the top cnt bits set (cnt = 0 → 4'b0000).
- out_last = (fsm == FLUSH) && (cnt ≤ 4).
- in_ready = (fsm == RUN) && (cnt < 4 || out_fire). in_ready depends combinationally on out_ready.
- Update order in one cycle:
  - On out_fire: base = acc << 32, c = cnt − 4. In FLUSH with cnt ≤ 4, c = 0.
  - Otherwise base = acc, c = cnt.
  - On in_fire: acc ← base | ({in_data, 32'b0} >> (8·c)), cnt ← c + in_len. Bytes beyond in_len in in_data are masked to zero before merge.
- in_len > 4 is illegal. The block clamps it to 4.
- cnt + in_len ≤ 7 always holds, so there is no overflow.
- FSM:
  - RUN → FLUSH on in_fire && in_last.
  - FLUSH → RUN on out_fire && out_last.
  - In FLUSH, in_ready = 0.
- Packet end with a partial remainder: one word with partial keep and last = 1.
- Exact multiple of 4 bytes: the final full word carries last = 1, with no extra word.
- Empty tail: in_last with cnt = 0 and in_len = 0 emits one word with keep 0000 and last = 1.

## Timing
- Reset (rst_n low, asynchronous): acc = 0, cnt = 0, fsm = RUN.
  - out_valid = 0, out_data = 0, out_keep = 0, out_last = 0.
  - in_ready forced to 0 while rst_n is low. It goes to 1 in the first cycle after release.
- Latency: a byte accepted in cycle N appears on out_data from cycle N+1.
- Throughput: 4 bytes/cycle sustained (simultaneous in_fire and out_fire are allowed).
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_keep and out_last hold stable.
  - out_valid does not drop until out_fire.
- Reset mid-packet or mid-flush discards all buffered bytes. There is no partial word after release.

## Structure
- Package byte_packer_pkg:
  - BYTES_PER_WORD = DATA_IN_WIDTH/8
  - CNT_WIDTH = 3
  - enum pack_state_t {RUN, FLUSH}
  - keep-mask function of cnt
- Sub-module byte_merge (combinational): takes chunk, byte offset and base accumulator; returns the merged 64-bit value and the new count.
- byte_packer holds the registers, FSM and handshake logic.

## Test plan
- Reset: assert rst_n low mid-stream → all outputs 0 asynchronously. One cycle after release, in_ready = 1 and out_valid = 0.
- Packing: chunks A1A2A3 (len 3), B1B2B3 (len 3), C1C2 (len 2), with out_ready = 1.
  - Words A1A2A3B1 then B2B3C1C2, keep 1111, last 0.
  - cnt = 0 afterwards.
- Backpressure: cnt = 5, out_ready = 0.
  - in_ready = 0; out_data is stable for 10 cycles.
  - On release, the word fires and in_ready = 1 in the same cycle.
- Partial flush: cnt = 0, chunk XY (len 2, last).
  - Word XY0000, keep 1100, last 1.
  - in_ready = 0 until that word fires, then 1.
- Exact and empty tails:
  - Chunk len 4, last → one word, keep 1111, last 1, no trailing word.
  - len 0, last with cnt = 0 → one word, keep 0000, last 1.
- Full-rate stream: 64 consecutive len-4 chunks with out_ready = 1 → 64 words on consecutive cycles with in_ready constantly 1.
- Random stall: out_ready toggling → byte order is preserved against the reference model.
